// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: decode/execute/mem/wb fields in,
// stage enables, squash controls, forwarding selects and event counters out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             de_valid;
   logic [4:0]       de_rs1;
   logic [4:0]       de_rs2;
   logic             ex_valid;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_is_final;
   logic [4:0]       mem_rd;
   logic             mem_reg_write;
   logic [4:0]       wb_rd;
   logic             wb_reg_write;
   logic             redirect;
   logic             cnt_clr;
   logic             fe_en;
   logic             de_en;
   logic             de_flush;
   logic             ex_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output de_valid, de_rs1, de_rs2,
      output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_is_final,
      output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
      output redirect, cnt_clr,
      input  fe_en, de_en, de_flush, ex_bubble, fwd_a, fwd_b,
      input  halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  de_valid, de_rs1, de_rs2,
      input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_is_final,
      input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
      input  redirect, cnt_clr,
      output fe_en, de_en, de_flush, ex_bubble, fwd_a, fwd_b,
      output halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, halt on final
// instruction, EX operand forwarding, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load_use;
   logic             final_ev;
   logic             fe_en;
   logic             de_en;
   logic             de_flush;
   logic             ex_bubble;
   logic             halted;
   logic             stall_issue;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs))
         sel = 2'b01;
      else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs))
         sel = 2'b10;
      return sel;
   endfunction

   assign load_use = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     bus.de_valid &&
                     ((bus.de_rs1 == bus.ex_rd) || (bus.de_rs2 == bus.ex_rd));
   assign final_ev = bus.ex_valid && bus.ex_is_final;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Next state and stage controls; reset forces the pipeline quiet and squashed.
   always_comb begin
      state_nxt   = state;
      fe_en       = 1'b1;
      de_en       = 1'b1;
      de_flush    = 1'b0;
      ex_bubble   = 1'b0;
      halted      = 1'b0;
      stall_issue = 1'b0;
      case (state)
         RUN: begin
            if (final_ev) begin
               state_nxt = HALT;
            end else if (bus.redirect) begin
               state_nxt = FLUSH;
               de_flush  = 1'b1;
               ex_bubble = 1'b1;
            end else if (load_use) begin
               state_nxt   = STALL;
               fe_en       = 1'b0;
               de_en       = 1'b0;
               ex_bubble   = 1'b1;
               stall_issue = 1'b1;
            end
         end
         STALL: begin
            if (final_ev)          state_nxt = HALT;
            else if (bus.redirect) state_nxt = FLUSH;
            else                   state_nxt = RUN;
         end
         FLUSH: begin
            de_flush  = 1'b1;
            ex_bubble = 1'b1;
            state_nxt = bus.redirect ? FLUSH : RUN;
         end
         HALT: begin
            fe_en     = 1'b0;
            de_en     = 1'b0;
            ex_bubble = 1'b1;
            halted    = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
      if (reset) begin
         state_nxt   = RUN;
         fe_en       = 1'b0;
         de_en       = 1'b0;
         de_flush    = 1'b1;
         ex_bubble   = 1'b1;
         halted      = 1'b0;
         stall_issue = 1'b0;
      end
   end

   // Saturating event counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (bus.cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_issue && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (de_flush && !(&flush_cnt))    flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign bus.fe_en     = fe_en;
   assign bus.de_en     = de_en;
   assign bus.de_flush  = de_flush;
   assign bus.ex_bubble = ex_bubble;
   assign bus.halted    = halted;
   assign bus.fwd_a     = fwd_sel(bus.ex_rs1);
   assign bus.fwd_b     = fwd_sel(bus.ex_rs2);
   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of stall and flush event counters.
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: de_valid in 1, de_rs1 in 5, de_rs2 in 5: validity and source registers of the instruction in decode.
REQ-005 SHALL have ports: ex_valid in 1, ex_rs1 in 5, ex_rs2 in 5, ex_rd in 5, ex_mem_read in 1, ex_is_final in 1: execute-stage instruction fields.
REQ-006 SHALL have ports: mem_rd in 5, mem_reg_write in 1, wb_rd in 5, wb_reg_write in 1: destinations in the MEM and WB stages.
REQ-007 SHALL have port: redirect  in  1  taken branch or jump resolved in EX this cycle.
REQ-008 SHALL have port: cnt_clr  in  1  synchronous clear of both counters.
REQ-009 SHALL have ports: fe_en out 1, de_en out 1: fetch and decode register enables.
REQ-010 SHALL have ports: de_flush out 1, ex_bubble out 1: squash decode input and insert a bubble into EX.
REQ-011 SHALL have ports: fwd_a out 2, fwd_b out 2: EX operand forwarding selects (00 reg file, 01 MEM, 10 WB).
REQ-012 SHALL have ports: halted out 1, stall_cnt out CNT_W, flush_cnt out CNT_W.

Function
REQ-013 SHALL implement a state machine with states RUN, STALL, FLUSH, HALT.
REQ-014 SHALL define load_use = ex_valid & ex_mem_read & ex_rd!=0 & de_valid & (de_rs1==ex_rd | de_rs2==ex_rd).
REQ-015 RUN priority SHALL be: ex_is_final&ex_valid -> HALT; else redirect -> FLUSH; else load_use -> STALL; else stay in RUN.
REQ-016 In RUN, outputs SHALL be combinational in the same cycle: redirect gives de_flush=1 and ex_bubble=1; load_use without redirect gives fe_en=0, de_en=0, ex_bubble=1.
REQ-017 In RUN with no event, outputs SHALL be fe_en=1, de_en=1, de_flush=0, ex_bubble=0.
REQ-018 STALL SHALL last exactly one cycle, then return to RUN.
REQ-019 In STALL, outputs SHALL be fe_en=1, de_en=1, ex_bubble=0, with events re-evaluated per REQ-015 priorities.
REQ-020 FLUSH SHALL assert de_flush=1 and ex_bubble=1 for one cycle to squash the wrong-path fetch, then return to RUN.
REQ-021 If redirect is asserted again while in FLUSH, the block SHALL remain in FLUSH for one further cycle.
REQ-022 HALT SHALL be terminal until reset, with fe_en=0, de_en=0, ex_bubble=1, halted=1.
REQ-023 fwd_a SHALL be 01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00.
REQ-024 fwd_b SHALL follow the same rule as fwd_a using ex_rs2.
REQ-025 fwd_a and fwd_b SHALL be purely combinational in every state, with MEM taking priority over WB.
REQ-026 stall_cnt SHALL increment once per cycle in which a load_use stall is issued.
REQ-027 flush_cnt SHALL increment once per cycle in which de_flush=1 outside reset.
REQ-028 Both counters SHALL saturate at all-ones; cnt_clr SHALL zero them and take priority over a same-cycle increment.

Reset
REQ-029 While reset is high, the block SHALL hold state=RUN, fe_en=0, de_en=0, de_flush=1, ex_bubble=1, halted=0, and both counters at 0.
REQ-030 Reset asserted mid-STALL, mid-FLUSH or in HALT SHALL return the block to RUN asynchronously, with no further counter update.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rd=5, de_rs1=5 -> that cycle fe_en=0, de_en=0, ex_bubble=1; next cycle fe_en=1; stall_cnt=1.
REQ-032 Redirect: single-cycle redirect=1 -> de_flush=1 on that cycle and the next; flush_cnt=2; state back in RUN on the third cycle.
REQ-033 Priority: redirect=1 together with load_use=1 -> FLUSH taken, fe_en=1, stall_cnt unchanged.
REQ-034 Forwarding: mem_rd=wb_rd=ex_rs1=7 with both write flags set -> fwd_a=01; with mem_reg_write=0 -> fwd_a=10; with ex_rs1=0 -> fwd_a=00.
REQ-035 Halt: ex_is_final=1, ex_valid=1 -> halted=1 from the next cycle; redirect is then ignored; reset returns halted=0.
REQ-036 Saturation and clear: with CNT_W=2, after 5 stalls stall_cnt=3; cnt_clr=1 together with a stall gives stall_cnt=0.
